// File: rtl/bus_arbiter_if.sv
// Shared-bus interface between the two bus masters (CPU, DMAC), the arbiter
// and the slave subsystem.
//   m0_*/m1_*   : per-master request, address, write data, direction, grant
//   bus_rdata   : read data returned by the slave subsystem
//   m_rdata     : read data broadcast back to both masters
//   addr/idata/rw_/free_ : slave-side bus driven by the arbiter
// Modports:
//   slave  - arbiter view (consumes master requests, drives grants/slave bus)
//   master - environment view (drives requests and slave read data)
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_rw_;
  logic              m0_gnt;
  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_rw_;
  logic              m1_gnt;
  logic [DATA_W-1:0] bus_rdata;
  logic [DATA_W-1:0] m_rdata;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] idata;
  logic              rw_;
  logic              free_;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_rw_,
    input  m1_req, m1_addr, m1_wdata, m1_rw_,
    input  bus_rdata,
    output m0_gnt, m1_gnt, m_rdata, addr, idata, rw_, free_
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_rw_,
    output m1_req, m1_addr, m1_wdata, m1_rw_,
    output bus_rdata,
    input  m0_gnt, m1_gnt, m_rdata, addr, idata, rw_, free_
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter and multiplexer with bounded tenure.
// Ports:
//   clk   - system clock, all state on rising edge
//   reset - asynchronous, active-high reset
//   bus   - bus_arbiter_if.slave: master requests in, grants out, slave-side
//           addr/idata/rw_/free_ out, bus_rdata in, m_rdata broadcast out
// Grants decode the registered state directly; the slave bus is muxed
// combinationally from state, so an asynchronous reset frees the bus at once.
module bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  hold_q, hold_d;

  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] idata_mux;
  logic              rw_mux;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) state_d = last_q ? OWN0 : OWN1;
        else if (bus.m0_req)          state_d = OWN0;
        else if (bus.m1_req)          state_d = OWN1;
      end
      OWN0: begin
        if (!bus.m0_req)                        state_d = bus.m1_req ? OWN1 : IDLE;
        else if (bus.m1_req && hold_q >= HOLD_LIM) state_d = OWN1;
      end
      OWN1: begin
        if (!bus.m1_req)                        state_d = bus.m0_req ? OWN0 : IDLE;
        else if (bus.m0_req && hold_q >= HOLD_LIM) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase

    // >= rather than == so a saturated counter (long uncontested tenure)
    // still yields to a newly arriving requester on the next edge.
    if (state_d != state_q) begin
      hold_d = '0;
      if (state_d == OWN0)      last_d = 1'b0;
      else if (state_d == OWN1) last_d = 1'b1;
    end else if (state_q != IDLE && hold_q != 8'hFF) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_comb begin
    addr_mux  = '0;
    idata_mux = '0;
    rw_mux    = 1'b1;
    unique case (state_q)
      OWN0: begin
        addr_mux  = bus.m0_addr;
        idata_mux = bus.m0_wdata;
        rw_mux    = bus.m0_rw_;
      end
      OWN1: begin
        addr_mux  = bus.m1_addr;
        idata_mux = bus.m1_wdata;
        rw_mux    = bus.m1_rw_;
      end
      default: ;
    endcase
  end

  assign bus.m0_gnt  = (state_q == OWN0);
  assign bus.m1_gnt  = (state_q == OWN1);
  assign bus.free_   = (state_q == IDLE);
  assign bus.addr    = addr_mux;
  assign bus.idata   = idata_mux;
  assign bus.rw_     = rw_mux;
  assign bus.m_rdata = bus.bus_rdata;

endmodule
